// File: rtl/calc_scheduler.sv
// ============================================================================
// Module   : calc_scheduler
// Purpose  : Round-robin scheduler sharing one calculator datapath among
//            NUM_REQ requesters, with a valid/ready tagged response channel.
// Options  : CALC_SCHED_STATS_EN adds stat_ops / stat_invalid counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module calc_scheduler #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_REQ      = 4,
  parameter int ID_WIDTH     = 2,
  parameter int CALC_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]          req_op,
  output logic [DATA_WIDTH-1:0]         calc_a,
  output logic [DATA_WIDTH-1:0]         calc_b,
  output logic [1:0]                    calc_op,
  input  logic [DATA_WIDTH-1:0]         calc_result,
  input  logic                          calc_invalid,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_result,
  output logic                          resp_invalid,
`ifdef CALC_SCHED_STATS_EN
  output logic [31:0]                   stat_ops,
  output logic [31:0]                   stat_invalid,
`endif
  output logic [ID_WIDTH-1:0]           resp_id
);

  localparam int CNT_W = (CALC_LATENCY > 1) ? $clog2(CALC_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   id_q;
  logic [CNT_W-1:0]      cnt;
  logic                  grant_any;
  logic                  hi_any;
  logic [ID_WIDTH-1:0]   hi_idx;
  logic [ID_WIDTH-1:0]   lo_idx;
  logic [ID_WIDTH-1:0]   grant;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [1:0]            sel_op;

  // Lowest requester above ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    grant_any = 1'b0;
    hi_any    = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_any = 1'b1;
        lo_idx    = ID_WIDTH'(i);
        if (ID_WIDTH'(i) > ptr) begin
          hi_any = 1'b1;
          hi_idx = ID_WIDTH'(i);
        end
      end
    end
    grant  = hi_any ? hi_idx : lo_idx;
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_WIDTH'(i) == grant) begin
        sel_a  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        sel_op = req_op[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (ID_WIDTH'(i) == grant);
          end
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers double as the calculator drive, so they hold between ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= ID_WIDTH'(NUM_REQ - 1);
      id_q         <= '0;
      cnt          <= '0;
      calc_a       <= '0;
      calc_b       <= '0;
      calc_op      <= '0;
      resp_valid   <= 1'b0;
      resp_result  <= '0;
      resp_invalid <= 1'b0;
      resp_id      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            calc_a  <= sel_a;
            calc_b  <= sel_b;
            calc_op <= sel_op;
            id_q    <= grant;
            ptr     <= grant;
            cnt     <= CNT_W'(CALC_LATENCY - 1);
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            resp_result  <= calc_result;
            resp_invalid <= calc_invalid;
            resp_id      <= id_q;
            resp_valid   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CALC_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops     <= '0;
      stat_invalid <= '0;
    end else if (resp_valid && resp_ready) begin
      stat_ops <= stat_ops + 32'd1;
      if (resp_invalid) begin
        stat_invalid <= stat_invalid + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_calc_scheduler.sv
// ============================================================================
// Module   : tb_calc_scheduler
// Purpose  : Scoreboard bench for calc_scheduler with a behavioural calculator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_calc_scheduler;

  localparam int DW  = 16;
  localparam int NR  = 4;
  localparam int IW  = 2;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a;
  logic [NR*DW-1:0]  req_b;
  logic [NR*2-1:0]   req_op;
  logic [DW-1:0]     calc_a;
  logic [DW-1:0]     calc_b;
  logic [1:0]        calc_op;
  logic [DW-1:0]     calc_result;
  logic              calc_invalid;
  logic              resp_valid;
  logic              resp_ready;
  logic [DW-1:0]     resp_result;
  logic              resp_invalid;
  logic [IW-1:0]     resp_id;
`ifdef CALC_SCHED_STATS_EN
  logic [31:0]       stat_ops;
  logic [31:0]       stat_invalid;
`endif

  always #5 clk = ~clk;

  calc_scheduler #(
    .DATA_WIDTH  (DW),
    .NUM_REQ     (NR),
    .ID_WIDTH    (IW),
    .CALC_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .calc_a      (calc_a),
    .calc_b      (calc_b),
    .calc_op     (calc_op),
    .calc_result (calc_result),
    .calc_invalid(calc_invalid),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_invalid(resp_invalid),
`ifdef CALC_SCHED_STATS_EN
    .stat_ops    (stat_ops),
    .stat_invalid(stat_invalid),
`endif
    .resp_id     (resp_id)
  );

  // Stand-in for the shared calculator instance.
  always_comb begin
    calc_invalid = 1'b0;
    case (calc_op)
      2'd0: calc_result = calc_a + calc_b;
      2'd1: calc_result = calc_a - calc_b;
      2'd2: calc_result = 16'(calc_a * calc_b);
      default: begin
        if (calc_b == '0) begin
          calc_result  = '0;
          calc_invalid = 1'b1;
        end else begin
          calc_result = calc_a / calc_b;
        end
      end
    endcase
  end

  typedef struct packed {
    logic [DW-1:0] res;
    logic          inv;
    logic [IW-1:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [1:0] op);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_op[i*2 +: 2]  = op;
    req_valid[i]      = 1'b1;
  endtask

  task automatic expect_resp(input logic [DW-1:0] res, input logic inv, input logic [IW-1:0] id);
    exp_q.push_back({res, inv, id});
  endtask

  task automatic wait_accept(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 100);
    if (!req_ready[i]) timeout($sformatf("accept_req%0d", i));
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_any_accept();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 100);
    if (req_ready == '0) timeout("accept_any");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  // Accept tracker: operand stability through EXEC and accept-to-valid latency.
  initial begin
    int            trk;
    logic [DW-1:0] cap_a;
    logic [DW-1:0] cap_b;
    logic [1:0]    cap_op;
    trk    = -1;
    cap_a  = '0;
    cap_b  = '0;
    cap_op = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        trk = -1;
      end else begin
        if (trk >= 1 && trk <= LAT) begin
          chk("exec_calc_a", 32'(calc_a), 32'(cap_a));
          chk("exec_calc_b", 32'(calc_b), 32'(cap_b));
          chk("exec_calc_op", 32'(calc_op), 32'(cap_op));
          chk("exec_resp_valid", 32'(resp_valid), 32'd0);
          chk("exec_req_ready", 32'(req_ready), 32'd0);
          trk++;
        end else if (trk == LAT + 1) begin
          chk("latency_resp_valid", 32'(resp_valid), 32'd1);
          trk = -1;
        end
        if (req_ready != '0) begin
          chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
          for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
              chk("ready_has_valid", 32'(req_valid[i]), 32'd1);
              cap_a  = req_a[i*DW +: DW];
              cap_b  = req_b[i*DW +: DW];
              cap_op = req_op[i*2 +: 2];
            end
          end
          trk = 1;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on each handshake, checks stalls.
  initial begin
    logic stalled;
    exp_t snap;
    exp_t e;
    stalled = 1'b0;
    snap    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else if (resp_valid) begin
        chk("resp_req_ready_zero", 32'(req_ready), 32'd0);
        if (stalled) begin
          chk("stall_result", 32'(resp_result), 32'(snap.res));
          chk("stall_invalid", 32'(resp_invalid), 32'(snap.inv));
          chk("stall_id", 32'(resp_id), 32'(snap.id));
        end
        if (resp_ready) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected: got id %0d result %0h expected no response",
                     resp_id, resp_result);
          end else begin
            e = exp_q.pop_front();
            chk("resp_result", 32'(resp_result), 32'(e.res));
            chk("resp_invalid", 32'(resp_invalid), 32'(e.inv));
            chk("resp_id", 32'(resp_id), 32'(e.id));
          end
        end else begin
          stalled = 1'b1;
          snap    = {resp_result, resp_invalid, resp_id};
        end
      end else if (stalled) begin
        chk("stall_valid_held", 32'(resp_valid), 32'd1);
        stalled = 1'b0;
      end
    end
  end

  initial begin
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b1;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_calc_a", 32'(calc_a), 32'd0);
    chk("rst_calc_b", 32'(calc_b), 32'd0);
    chk("rst_calc_op", 32'(calc_op), 32'd0);
    chk("rst_resp_result", 32'(resp_result), 32'd0);
    chk("rst_resp_invalid", 32'(resp_invalid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    @(posedge clk);
    #1;

    // Single requests: add, sub wrap, mul truncation, divide by zero.
    set_req(0, 16'd7, 16'd5, 2'b00);
    expect_resp(16'd12, 1'b0, 2'd0);
    wait_accept(0);
    wait_drain();

    set_req(1, 16'd3, 16'd5, 2'b01);
    expect_resp(16'hFFFE, 1'b0, 2'd1);
    wait_accept(1);
    wait_drain();

    set_req(2, 16'd300, 16'd300, 2'b10);
    expect_resp(16'h5F90, 1'b0, 2'd2);
    wait_accept(2);
    wait_drain();

    set_req(3, 16'd9, 16'd0, 2'b11);
    expect_resp(16'd0, 1'b1, 2'd3);
    wait_accept(3);
    wait_drain();

    // All four contending: order 0,1,2,3 then wrap to 0.
    set_req(0, 16'd10, 16'd20, 2'b00);
    set_req(1, 16'd100, 16'd1, 2'b01);
    set_req(2, 16'd6, 16'd7, 2'b10);
    set_req(3, 16'd100, 16'd7, 2'b11);
    expect_resp(16'd30, 1'b0, 2'd0);
    expect_resp(16'd99, 1'b0, 2'd1);
    expect_resp(16'd42, 1'b0, 2'd2);
    expect_resp(16'd14, 1'b0, 2'd3);
    expect_resp(16'd30, 1'b0, 2'd0);
    for (int g = 0; g < 5; g++) wait_any_accept();
    req_valid = '0;
    wait_drain();

    // Back-pressure: response held 5 cycles while another request waits.
    resp_ready = 1'b0;
    set_req(2, 16'hFFFF, 16'd1, 2'b00);
    expect_resp(16'd0, 1'b0, 2'd2);
    wait_accept(2);
    set_req(0, 16'd2, 16'd3, 2'b10);
    expect_resp(16'd6, 1'b0, 2'd0);
    begin
      int n = 0;
      while (!resp_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!resp_valid) timeout("stall_resp_valid");
    end
    repeat (5) @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_accept(0);
    wait_drain();

    // Reset in the middle of EXEC drops the op and restores the pointer.
    set_req(1, 16'd5, 16'd5, 2'b00);
    wait_accept(1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_calc_a", 32'(calc_a), 32'd0);
    @(posedge clk);
    #1;
    set_req(0, 16'd4, 16'd4, 2'b01);
    set_req(1, 16'h1234, 16'h0010, 2'b10);
    expect_resp(16'd0, 1'b0, 2'd0);
    expect_resp(16'h2340, 1'b0, 2'd1);
    wait_accept(0);
    wait_accept(1);
    wait_drain();

    repeat (4) @(negedge clk);
    chk("final_idle_resp_valid", 32'(resp_valid), 32'd0);
`ifdef CALC_SCHED_STATS_EN
    chk("stat_ops", stat_ops, 32'd2);
    chk("stat_invalid", stat_invalid, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
